// File: rtl/writeback_arbiter_l4_pkg.sv
// -----------------------------------------------------------------------------
// WbPkg : shared types and constants for the L4 writeback arbiter.
// t_x__w_msg carries one execute result (X__W message). The sequence-number
// field is sized by WB_MAX_SEQ_BITS; narrower configurations zero-extend
// into it and truncate on the way out.
// -----------------------------------------------------------------------------
package WbPkg;

  // Widest sequence number any instance may carry.
  localparam int WB_MAX_SEQ_BITS = 32;

  // Architectural zero register; writes to it never reach the register file.
  localparam logic [4:0] WB_ZERO_REG = 5'd0;

  typedef struct packed {
    logic [31:0]                pc;
    logic [WB_MAX_SEQ_BITS-1:0] seq_num;
    logic [4:0]                 waddr;
    logic [31:0]                wdata;
    logic                       wen;
  } t_x__w_msg;

  // True when the message performs a real register-file write.
  function automatic logic wb_is_reg_write(input t_x__w_msg msg);
    return msg.wen && (msg.waddr != WB_ZERO_REG);
  endfunction

endpackage

// File: rtl/writeback_arbiter_l4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter with an internal priority pointer.
// Grants the first requester found searching circularly from the pointer.
// When a grant is issued the pointer moves to one past the granted index,
// wrapping to 0 after p_width-1. en = 0 suppresses every grant.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int p_width = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  input  logic               en,
  output logic [p_width-1:0] gr
);

  localparam int PW = (p_width > 1) ? $clog2(p_width) : 1;
  localparam logic [PW:0] LP_WIDTH = (PW+1)'(p_width);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_any;
  logic [PW:0]   w_pos;
  logic [PW:0]   w_after;

  // Circular priority search starting at the pointer; records the next pointer.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    gr        = '0;
    w_any     = 1'b0;
    w_ptr_nxt = r_ptr;
    w_pos     = '0;
    w_after   = '0;
    for (int k = 0; k < p_width; k++) begin
      w_pos = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_pos >= LP_WIDTH) begin
        w_pos = w_pos - LP_WIDTH;
      end
      if (en && !w_any && req[w_pos[PW-1:0]]) begin
        gr[w_pos[PW-1:0]] = 1'b1;
        w_any             = 1'b1;
        w_after           = w_pos + 1'b1;
        if (w_after == LP_WIDTH) begin
          w_after = '0;
        end
        w_ptr_nxt = w_after[PW-1:0];
      end
    end
  end

  // Priority pointer: back to 0 on reset, advances only on a grant.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/writeback_arbiter_l4.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_l4 : L4 writeback stage.
// Selects one X__W message per cycle from p_num_pipes execute pipes using
// round-robin arbitration, registers it for exactly one cycle, and drives the
// register-file write port and a one-cycle commit notification.
// The output register drains every cycle, so any grant is a transfer.
//
// Optional feature, macro WB_ARB_FWD_EN: adds fwd_val/fwd_waddr/fwd_wdata,
// driven combinationally from the granted input so decode can bypass one
// cycle earlier. Without the macro these ports and their logic do not exist.
// -----------------------------------------------------------------------------
module writeback_arbiter_l4
  import WbPkg::*;
#(
  parameter int p_num_pipes    = 3,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                x_val,
  output logic [p_num_pipes-1:0]                x_rdy,
  input  logic [32*p_num_pipes-1:0]             x_pc,
  input  logic [p_seq_num_bits*p_num_pipes-1:0] x_seq_num,
  input  logic [5*p_num_pipes-1:0]              x_waddr,
  input  logic [32*p_num_pipes-1:0]             x_wdata,
  input  logic [p_num_pipes-1:0]                x_wen,
  output logic                                  rf_wen,
  output logic [4:0]                            rf_waddr,
  output logic [31:0]                           rf_wdata,
  output logic                                  commit_val,
  output logic [31:0]                           commit_pc,
  output logic [p_seq_num_bits-1:0]             commit_seq_num
`ifdef WB_ARB_FWD_EN
  ,
  output logic                                  fwd_val,
  output logic [4:0]                            fwd_waddr,
  output logic [31:0]                           fwd_wdata
`endif
);

  logic [p_num_pipes-1:0] w_gr;
  logic                   w_xfer;
  t_x__w_msg              w_sel;
  logic                   w_out_val;

  logic                   r_wb_val;
  t_x__w_msg              r_msg;

  // Arbitration is disabled while reset is asserted, which keeps x_rdy at 0.
  rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_rr_arbiter (
    .clk (clk),
    .rst (rst),
    .req (x_val),
    .en  (~rst),
    .gr  (w_gr)
  );

  assign x_rdy  = w_gr;
  assign w_xfer = |w_gr;

  // One-hot mux of the granted pipe's fields; all-zero when nothing is granted.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (w_gr[i]) begin
        w_sel.pc      = x_pc[32*i +: 32];
        w_sel.seq_num = WB_MAX_SEQ_BITS'(x_seq_num[p_seq_num_bits*i +: p_seq_num_bits]);
        w_sel.waddr   = x_waddr[5*i +: 5];
        w_sel.wdata   = x_wdata[32*i +: 32];
        w_sel.wen     = x_wen[i];
      end
    end
  end

  // Output register: loads the granted message, otherwise clears to zero.
  always_ff @(posedge clk) begin
    // NOTE: the data fields are reset as well as the valid bit, because the
    // outputs must never expose stale contents after reset or an idle cycle.
    if (rst) begin
      r_wb_val <= 1'b0;
      r_msg    <= '0;
    end else begin
      r_wb_val <= w_xfer;
      r_msg    <= w_sel;
    end
  end

  // An in-flight message is dropped if reset arrives while it is presented.
  assign w_out_val = r_wb_val & ~rst;

  assign commit_val     = w_out_val;
  assign commit_pc      = w_out_val ? r_msg.pc : 32'd0;
  assign commit_seq_num = w_out_val ? p_seq_num_bits'(r_msg.seq_num) : '0;
  assign rf_wen         = w_out_val & wb_is_reg_write(r_msg);
  assign rf_waddr       = w_out_val ? r_msg.waddr : 5'd0;
  assign rf_wdata       = w_out_val ? r_msg.wdata : 32'd0;

`ifdef WB_ARB_FWD_EN
  // Early bypass of the result being accepted this cycle.
  assign fwd_val   = w_xfer & wb_is_reg_write(w_sel);
  assign fwd_waddr = w_sel.waddr;
  assign fwd_wdata = w_sel.wdata;
`endif

endmodule

// File: tb/tb_writeback_arbiter_l4.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter_l4 : scoreboard bench for writeback_arbiter_l4.
// The stimulus process drives directed vectors, checks x_rdy, and pushes the
// expected commit for every transfer. A monitor on the falling edge pops and
// compares whenever commit_val is seen, and checks idle outputs are zero.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter_l4;

  localparam int N  = 3;
  localparam int SB = 5;

  typedef struct packed {
    logic [31:0]   pc;
    logic [SB-1:0] seq;
    logic          wen;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [N-1:0]      x_val;
  logic [N-1:0]      x_rdy;
  logic [32*N-1:0]   x_pc;
  logic [SB*N-1:0]   x_seq_num;
  logic [5*N-1:0]    x_waddr;
  logic [32*N-1:0]   x_wdata;
  logic [N-1:0]      x_wen;
  logic              rf_wen;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              commit_val;
  logic [31:0]       commit_pc;
  logic [SB-1:0]     commit_seq_num;
`ifdef WB_ARB_FWD_EN
  logic              fwd_val;
  logic [4:0]        fwd_waddr;
  logic [31:0]       fwd_wdata;
`endif

  logic [31:0]   t_pc    [N];
  logic [SB-1:0] t_seq   [N];
  logic [4:0]    t_waddr [N];
  logic [31:0]   t_wdata [N];
  logic          t_wen   [N];

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  writeback_arbiter_l4 #(
    .p_num_pipes    (N),
    .p_seq_num_bits (SB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .x_val          (x_val),
    .x_rdy          (x_rdy),
    .x_pc           (x_pc),
    .x_seq_num      (x_seq_num),
    .x_waddr        (x_waddr),
    .x_wdata        (x_wdata),
    .x_wen          (x_wen),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .commit_val     (commit_val),
    .commit_pc      (commit_pc),
    .commit_seq_num (commit_seq_num)
`ifdef WB_ARB_FWD_EN
    ,
    .fwd_val        (fwd_val),
    .fwd_waddr      (fwd_waddr),
    .fwd_wdata      (fwd_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_pipe(input int i, input logic [31:0] pc, input logic [SB-1:0] seq,
                          input logic [4:0] waddr, input logic [31:0] wdata, input logic wen);
    t_pc[i]    = pc;
    t_seq[i]   = seq;
    t_waddr[i] = waddr;
    t_wdata[i] = wdata;
    t_wen[i]   = wen;
  endtask

  // Drive one cycle of requests; g is the pipe expected to be granted (-1: none).
  // push = 0 marks a transfer whose commit is expected to be discarded.
  task automatic step(input logic [N-1:0] val, input int g, input bit push);
    logic [N-1:0] exp_rdy;
    exp_t         e;
    x_val = val;
    for (int i = 0; i < N; i++) begin
      x_pc[32*i +: 32]     = t_pc[i];
      x_seq_num[SB*i +: SB] = t_seq[i];
      x_waddr[5*i +: 5]    = t_waddr[i];
      x_wdata[32*i +: 32]  = t_wdata[i];
      x_wen[i]             = t_wen[i];
    end
    #1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("x_rdy", x_rdy, exp_rdy);
`ifdef WB_ARB_FWD_EN
    if (g >= 0) begin
      check("fwd", {fwd_val, fwd_waddr, fwd_wdata},
            {t_wen[g] && (t_waddr[g] != 5'd0), t_waddr[g], t_wdata[g]});
    end else begin
      check("fwd_idle", fwd_val, 1'b0);
    end
`endif
    if (g >= 0 && push) begin
      e.pc    = t_pc[g];
      e.seq   = t_seq[g];
      e.wen   = t_wen[g] && (t_waddr[g] != 5'd0);
      e.waddr = t_waddr[g];
      e.wdata = t_wdata[g];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented commit against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("reset_outputs", {commit_val, rf_wen, rf_waddr, rf_wdata, commit_pc, commit_seq_num}, '0);
    end else if (commit_val) begin
      if (sb_q.size() == 0) begin
        check("commit_unexpected", commit_val, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("commit", {commit_pc, commit_seq_num, rf_wen, rf_waddr, rf_wdata}, e);
      end
    end else begin
      check("idle_zero", {rf_wen, rf_waddr, rf_wdata, commit_pc, commit_seq_num}, '0);
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) set_pipe(i, 32'd0, '0, 5'd0, 32'd0, 1'b0);
    rst       = 1'b1;
    x_val     = '1;
    x_pc      = '0;
    x_seq_num = '0;
    x_waddr   = '0;
    x_wdata   = '0;
    x_wen     = '0;
    @(posedge clk);
    #1;
    check("reset_rdy", x_rdy, '0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    x_val = '0;

    // Pipe 0 alone: full register write.
    set_pipe(0, 32'h0000_0200, 5'd3, 5'd5, 32'hDEAD_BEEF, 1'b1);
    step(3'b001, 0, 1'b1);
    // Pipe 1 writes x0: commit pulses, rf_wen suppressed.
    set_pipe(1, 32'h0000_0300, 5'd4, 5'd0, 32'h0000_1234, 1'b1);
    step(3'b010, 1, 1'b1);
    // Pipe 2 alone moves the pointer back to 0.
    set_pipe(2, 32'h0000_0400, 5'd6, 5'd9, 32'hAAAA_5555, 1'b1);
    step(3'b100, 2, 1'b1);

    // All pipes valid for 6 cycles: grants rotate 0,1,2,0,1,2.
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < N; p++) begin
        set_pipe(p, 32'h0000_1000 + 32'(c * 16 + p * 4), SB'(c * 3 + p + 8),
                 5'(p + 1), 32'(c * 256 + p), 1'b1);
      end
      step(3'b111, c % 3, 1'b1);
    end
    step(3'b000, -1, 1'b0);

    // Wrap-around: bring ptr to 2, then pipes 2 and 0 valid.
    set_pipe(1, 32'h0000_0700, 5'd17, 5'd11, 32'h0000_0B0B, 1'b1);
    step(3'b010, 1, 1'b1);
    set_pipe(0, 32'h0000_0800, 5'd18, 5'd12, 32'h0000_0C0C, 1'b1);
    set_pipe(2, 32'h0000_0900, 5'd19, 5'd13, 32'h0000_0D0D, 1'b1);
    step(3'b101, 2, 1'b1);
    step(3'b101, 0, 1'b1);

    // Pipe 1 without write enable: commit pulses, rf_wen stays low.
    set_pipe(1, 32'h0000_0500, 5'd21, 5'd7, 32'h0000_0077, 1'b0);
    step(3'b010, 1, 1'b1);

    // Transfer from pipe 1 (ptr -> 2), then reset discards it.
    set_pipe(1, 32'h0000_0600, 5'd22, 5'd3, 32'h0000_0066, 1'b1);
    step(3'b010, 1, 1'b0);
    rst   = 1'b1;
    x_val = 3'b111;
    #1;
    check("reset_mid_rdy", x_rdy, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Pointer is back at 0, so pipe 1 wins over pipe 2.
    set_pipe(1, 32'h0000_0A00, 5'd23, 5'd4, 32'h0000_00A4, 1'b1);
    set_pipe(2, 32'h0000_0B00, 5'd24, 5'd6, 32'h0000_00B6, 1'b1);
    step(3'b110, 1, 1'b1);
    step(3'b000, -1, 1'b0);
    step(3'b000, -1, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
